// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
//
// Shares one pipelined multiplier among NUM_REQ requesters. A round-robin
// arbiter issues at most one operand pair per cycle. A tag pipeline that
// runs beside the multiplier records which requester owns each in-flight
// product, so the finished product can be routed back as a one-hot strobe.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   en           arbitration enable (0 = no new grants, in-flight ops finish)
//   req_valid    per-requester operation valid
//   req_ready    per-requester grant, one-hot or zero
//   req_a/req_b  packed operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mul_a/mul_b  operands to the multiplier (zero when nothing is issued)
//   mul_result   product from the multiplier, MULT_LATENCY edges after capture
//   rsp_valid    one-hot single-cycle response strobe
//   rsp_data     product, broadcast to all requesters
//   busy         an operation is in flight or a response is being presented
//   op_count     accepted-operation counter, wraps at 2^32
// ---------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REQ      = 4,
    parameter int MULT_LATENCY = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [DATA_WIDTH-1:0]         mul_a,
    output logic [DATA_WIDTH-1:0]         mul_b,
    input  logic [2*DATA_WIDTH-1:0]       mul_result,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [2*DATA_WIDTH-1:0]       rsp_data,
    output logic                          busy,
    output logic [31:0]                   op_count
);

    localparam int              ID_W      = $clog2(NUM_REQ);
    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    logic [DATA_WIDTH-1:0]   a_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]   b_arr [NUM_REQ];

    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [31:0]             op_count_q, op_count_d;
    logic [MULT_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]         tag_id_q [MULT_LATENCY];
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [ID_W:0]           sum;
    logic [ID_W-1:0]         cand;
    logic [ID_W-1:0]         winner;
    logic                    found;
    logic                    grant;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*DATA_WIDTH +: DATA_WIDTH];
        assign b_arr[g] = req_b[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search rr_ptr, rr_ptr+1, ... for the first valid requester. The wrap is
    // an explicit compare so non-power-of-two NUM_REQ cycles correctly.
    always_comb begin
        sum    = '0;
        cand   = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            cand = sum[ID_W-1:0];
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Reset also masks the grant so nothing is offered while rst is high.
    assign grant = found & en & ~rst;

    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
            mul_a             = a_arr[winner];
            mul_b             = b_arr[winner];
        end
    end

    // The accept edge is also the multiplier's capture edge, so the product
    // shows up after MULT_LATENCY edges; the tag takes as many registers to
    // sit in the last stage exactly while mul_result holds its product.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        op_count_d  = op_count_q + {31'b0, grant};
        tag_vld_d   = {tag_vld_q[MULT_LATENCY-2:0], grant};
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (grant) begin
            rr_ptr_d = (winner == LAST_ID) ? '0 : winner + ID_W'(1);
        end
        if (tag_vld_q[MULT_LATENCY-1]) begin
            rsp_valid_d[tag_id_q[MULT_LATENCY-1]] = 1'b1;
            rsp_data_d                            = mul_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
            tag_vld_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            op_count_q  <= op_count_d;
            tag_vld_q   <= tag_vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Ids are qualified by tag_vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= winner;
        for (int i = 1; i < MULT_LATENCY; i++) begin
            tag_id_q[i] <= tag_id_q[i-1];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign op_count  = op_count_q;
    assign busy      = (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              en  = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a = '0;
    logic [NR*DW-1:0]  req_b = '0;
    logic [DW-1:0]     mul_a, mul_b;
    logic [2*DW-1:0]   mul_result;
    logic [NR-1:0]     rsp_valid;
    logic [2*DW-1:0]   rsp_data;
    logic              busy;
    logic [31:0]       op_count;

    typedef struct {
        int          id;
        logic [63:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          exp_ptr = 0;
    logic [31:0] exp_cnt = '0;
    bit          sb_on  = 1'b0;
    logic [DW-1:0] op_a [NR];
    logic [DW-1:0] op_b [NR];

    mult_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MULT_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural shared multiplier: registered inputs, LAT edges to output.
    logic [63:0] mp [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) mp[i] <= '0;
        end else begin
            mp[0] <= {32'b0, mul_a} * {32'b0, mul_b};
            for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
        end
    end
    assign mul_result = mp[LAT-1];

    // Scoreboard: every cycle rsp_valid must match the entry due now, or be 0.
    always @(negedge clk) begin : mon
        exp_t          e;
        logic [NR-1:0] ev;
        if (sb_on) begin
            checks++;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e  = sb_q.pop_front();
                ev = '0;
                ev[e.id] = 1'b1;
                if (rsp_valid !== ev || rsp_data !== e.data) begin
                    errors++;
                    $display("FAIL rsp cyc=%0d: got valid=%b data=%h, want valid=%b data=%h",
                             cyc, rsp_valid, rsp_data, ev, e.data);
                end
            end else if (rsp_valid !== '0) begin
                errors++;
                $display("FAIL rsp_idle cyc=%0d: got valid=%b, want 0000", cyc, rsp_valid);
            end
        end
    end

    task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
        op_a[i] = a;
        op_b[i] = b;
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
    endtask

    task automatic push_exp(input int id, input logic [63:0] p);
        sb_q.push_back('{id: id, data: p, due: cyc + LAT + 1});
        exp_ptr = (id + 1) % NR;
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        sb_q.delete();
        exp_ptr = 0;
        exp_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        sb_on = 1'b1;
        #1;
        checks++;
        if (req_ready !== '0 || mul_a !== '0 || mul_b !== '0) begin
            errors++;
            $display("FAIL reset_drive: got ready=%b a=%h b=%h, want 0", req_ready, mul_a, mul_b);
        end
        checks++;
        if (rsp_valid !== '0 || rsp_data !== '0 || busy !== 1'b0 || op_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_status: got rv=%b rd=%h busy=%b cnt=%h, want 0",
                     rsp_valid, rsp_data, busy, op_count);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req_valid = 4'b0100;
        set_op(2, 32'd7, 32'd6);
        #1;
        checks++;
        if (req_ready !== 4'b0100 || mul_a !== 32'd7 || mul_b !== 32'd6) begin
            errors++;
            $display("FAIL single_grant: got ready=%b a=%0d b=%0d, want 0100 7 6",
                     req_ready, mul_a, mul_b);
        end
        push_exp(2, 64'd42);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = '0;
            #1;
            checks++;
            if (busy !== (c <= 4)) begin
                errors++;
                $display("FAIL single_busy c=%0d: got %b want %b", c, busy, (c <= 4));
            end
            if (c == 1) begin
                checks++;
                if (op_count !== 32'd1) begin
                    errors++;
                    $display("FAIL single_count: got %0d want 1", op_count);
                end
            end
            if (c == 4) begin
                checks++;
                if (rsp_valid !== 4'b0100 || rsp_data !== 64'd42) begin
                    errors++;
                    $display("FAIL single_rsp: got %b %0d want 0100 42", rsp_valid, rsp_data);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int            prev;
        logic [NR-1:0] oh;
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, $urandom(), $urandom());
        prev = -1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            if (prev >= 0) set_op(prev, $urandom(), $urandom());
            #1;
            oh = '0;
            oh[n % NR] = 1'b1;
            checks++;
            if (req_ready !== oh || mul_a !== op_a[n % NR] || mul_b !== op_b[n % NR]) begin
                errors++;
                $display("FAIL rr_grant n=%0d: got ready=%b a=%h, want %b a=%h",
                         n, req_ready, mul_a, oh, op_a[n % NR]);
            end
            push_exp(n % NR, {32'b0, op_a[n % NR]} * {32'b0, op_b[n % NR]});
            prev = n % NR;
        end
        @(negedge clk);
        req_valid = '0;
        repeat (LAT + 3) @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0 || op_count !== exp_cnt) begin
            errors++;
            $display("FAIL rr_drain: got pending=%0d cnt=%0d, want 0 %0d",
                     sb_q.size(), op_count, exp_cnt);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        req_valid = 4'b0010;
        set_op(1, 32'd3, 32'd4);
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL prio_setup: got %b want 0010", req_ready);
        end
        push_exp(1, 64'd12);
        @(negedge clk);
        req_valid = 4'b1010;
        set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        set_op(1, 32'd0, 32'd5);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL prio_first: got %b want 1000", req_ready);
        end
        push_exp(3, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0010 || mul_a !== 32'd0 || mul_b !== 32'd5) begin
            errors++;
            $display("FAIL prio_second: got %b a=%0d b=%0d want 0010 0 5", req_ready, mul_a, mul_b);
        end
        push_exp(1, 64'd0);
        @(negedge clk);
        req_valid = '0;
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL prio_drain: got pending=%0d want 0", sb_q.size());
        end
    endtask

    task automatic test_enable();
        @(negedge clk);
        for (int i = 0; i < NR; i++) set_op(i, 32'(i + 2), 32'(i + 11));
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL en_first: got %b want 0100", req_ready);
        end
        push_exp(2, 64'd4 * 64'd13);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            en = 1'b0;
            #1;
            checks++;
            if (req_ready !== '0 || mul_a !== '0 || mul_b !== '0) begin
                errors++;
                $display("FAIL en_off c=%0d: got ready=%b a=%h b=%h want 0", c, req_ready, mul_a, mul_b);
            end
        end
        @(negedge clk);
        en = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL en_resume: got %b want 1000", req_ready);
        end
        push_exp(3, 64'd5 * 64'd14);
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL en_wrap: got %b want 0001", req_ready);
        end
        push_exp(0, 64'd2 * 64'd11);
        @(negedge clk);
        req_valid = '0;
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL en_drain: got pending=%0d want 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        for (int i = 0; i < NR; i++) set_op(i, 32'(100 + i), 32'(3));
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL rstmid_g0: got %b want 0010", req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL rstmid_g1: got %b want 0100", req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        exp_ptr = 0;
        exp_cnt = '0;
        #1;
        checks++;
        if (req_ready !== '0 || mul_a !== '0 || mul_b !== '0 || rsp_valid !== '0 ||
            rsp_data !== '0 || busy !== 1'b0 || op_count !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_zero: got ready=%b a=%h rv=%b rd=%h busy=%b cnt=%0d want all 0",
                     req_ready, mul_a, rsp_valid, rsp_data, busy, op_count);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001 || op_count !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_after: got ready=%b cnt=%0d want 0001 0", req_ready, op_count);
        end
        push_exp(0, 64'd300);
        @(negedge clk);
        req_valid = '0;
        repeat (LAT + 4) @(negedge clk);
        checks++;
        if (sb_q.size() != 0 || op_count !== 32'd1) begin
            errors++;
            $display("FAIL rstmid_drain: got pending=%0d cnt=%0d want 0 1", sb_q.size(), op_count);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.op_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.op_count_q;
        req_valid = 4'b0001;
        set_op(0, 32'd9, 32'd9);
        #1;
        checks++;
        if (op_count !== 32'hFFFF_FFFE || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_pre: got cnt=%h ready=%b want fffffffe 0001", op_count, req_ready);
        end
        push_exp(0, 64'd81);
        @(negedge clk);
        #1;
        checks++;
        if (op_count !== 32'hFFFF_FFFF || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_max: got cnt=%h ready=%b want ffffffff 0001", op_count, req_ready);
        end
        push_exp(0, 64'd81);
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if (op_count !== 32'd0) begin
            errors++;
            $display("FAIL wrap_zero: got cnt=%h want 00000000", op_count);
        end
        repeat (LAT + 3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain: got pending=%0d want 0", sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_enable();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got time %0t want < 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
